// File: rtl/imem_loader_if.sv
// Byte-stream input handshake and instruction-memory write port of the program loader.
interface imem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;

  // Stream source / memory side
  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_waddr, imem_wdata
  );

  // Loader side
  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader: LEN_LO, LEN_HI, 4*N little-endian data bytes, XOR checksum byte.
// Writes the instruction memory word by word and holds the CPU until a verified image is in.
module imem_loader #(
  parameter int          MAX_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  imem_loader_if.slave bus,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] words_written
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [23:0] shreg;
  logic [1:0]  byte_cnt;
  logic [7:0]  csum;
  logic        xfer;
  logic        restart;
  logic [15:0] len_full;
  logic        last_word;

  assign bus.in_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                        (state == S_DATA)   || (state == S_CSUM);
  assign xfer      = bus.in_valid && bus.in_ready;
  assign restart   = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign len_full  = {bus.in_data, len_lo};
  assign last_word = (words_written + 16'd1) == len;

  assign cpu_hold   = (state != S_DONE);
  assign load_done  = (state == S_DONE);
  assign load_error = (state == S_ERROR);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_LEN_LO;
      S_LEN_LO: if (xfer) state_nxt = S_LEN_HI;
      S_LEN_HI: begin
        if (xfer) begin
          if (len_full == 16'd0)         state_nxt = S_CSUM;
          else if (len_full > MAX_LEN)   state_nxt = S_ERROR;
          else                           state_nxt = S_DATA;
        end
      end
      // The last word's strobe cycle is spent in CSUM, which already accepts bytes.
      S_DATA: if (xfer && (byte_cnt == 2'd3) && last_word) state_nxt = S_CSUM;
      S_CSUM: if (xfer) state_nxt = (bus.in_data == csum) ? S_DONE : S_ERROR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      byte_cnt       <= 2'd0;
      csum           <= 8'd0;
      words_written  <= 16'd0;
      bus.imem_we    <= 1'b0;
      bus.imem_waddr <= 32'd0;
      bus.imem_wdata <= 32'd0;
    end else begin
      state       <= state_nxt;
      bus.imem_we <= 1'b0;
      if (restart) begin
        words_written <= 16'd0;
        csum          <= 8'd0;
        byte_cnt      <= 2'd0;
      end
      if (xfer) begin
        case (state)
          S_LEN_LO: len_lo <= bus.in_data;
          S_LEN_HI: len    <= len_full;
          S_DATA: begin
            csum     <= csum ^ bus.in_data;
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= {bus.in_data, shreg[23:8]};
            if (byte_cnt == 2'd3) begin
              bus.imem_we    <= 1'b1;
              bus.imem_wdata <= {bus.in_data, shreg};
              bus.imem_waddr <= BASE_ADDR + {14'd0, words_written, 2'b00};
              words_written  <= words_written + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: frames are built from word images and the expected
// memory writes / final status are derived from the frame rules.
module tb_imem_loader;
  localparam int          MAX_WORDS = 1024;
  localparam logic [31:0] BASE_ADDR = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cpu_hold, load_done, load_error;
  logic [15:0] words_written;

  imem_loader_if bus();

  imem_loader #(.MAX_WORDS(MAX_WORDS), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] img[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [7:0]  csum_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wa_q.push_back(bus.imem_waddr);
      wd_q.push_back(bus.imem_wdata);
    end
  end

  task automatic fill(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int g;
    int t;
    g = (gapmax > 0) ? int'($urandom_range(gapmax, 1)) : 0;
    repeat (g) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (bus.in_ready !== 1'b1) chk("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic start_load(input logic [15:0] n, input int gapmax);
    wa_q.delete();
    wd_q.delete();
    csum_acc = 8'd0;
    pulse_start();
    send_byte(n[7:0], gapmax);
    send_byte(n[15:8], gapmax);
  endtask

  // Sends image bytes with indices [from, to), byte k of word i is img[i][8k+:8].
  task automatic send_data(input int from, input int to, input int gapmax);
    logic [31:0] w;
    logic [7:0]  b;
    for (int j = from; j < to; j++) begin
      w = img[j / 4];
      b = w[8 * (j % 4) +: 8];
      csum_acc = csum_acc ^ b;
      send_byte(b, gapmax);
    end
  endtask

  task automatic check_result(input string tag, input int n, input logic ok);
    chk({tag, "_nwrites"}, wa_q.size(), n);
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wa_q[i], BASE_ADDR + 32'(4 * i));
      chk($sformatf("%s_data%0d", tag, i), wd_q[i], img[i]);
    end
    chk({tag, "_done"},  {31'd0, load_done},  {31'd0, ok});
    chk({tag, "_error"}, {31'd0, load_error}, {31'd0, !ok});
    chk({tag, "_hold"},  {31'd0, cpu_hold},   {31'd0, !ok});
    chk({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_ww"},    {16'd0, words_written}, 32'(n));
  endtask

  // csum_ovr[8]=1 sends csum_ovr[7:0] instead of the correct checksum.
  task automatic full_load(input string tag, input int n, input logic [8:0] csum_ovr,
                           input int gapmax);
    logic [7:0] cb;
    start_load(16'(n), gapmax);
    if (n > MAX_WORDS) begin
      repeat (3) @(negedge clk);
      chk({tag, "_nwrites"}, wa_q.size(), 0);
      chk({tag, "_error"}, {31'd0, load_error}, 32'd1);
      chk({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd0);
      chk({tag, "_hold"},  {31'd0, cpu_hold}, 32'd1);
      return;
    end
    send_data(0, 4 * n, gapmax);
    cb = csum_ovr[8] ? csum_ovr[7:0] : csum_acc;
    send_byte(cb, gapmax);
    repeat (2) @(negedge clk);
    check_result(tag, n, cb == csum_acc);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_we",    {31'd0, bus.imem_we}, 32'd0);
    chk("rst_waddr", bus.imem_waddr, 32'd0);
    chk("rst_wdata", bus.imem_wdata, 32'd0);
    chk("rst_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("rst_done",  {31'd0, load_done}, 32'd0);
    chk("rst_error", {31'd0, load_error}, 32'd0);
    chk("rst_ww",    {16'd0, words_written}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'd0, bus.in_ready}, 32'd0);

    // Two-word directed image.
    img.delete();
    img.push_back(32'h0000_0013);
    img.push_back(32'h0010_00B3);
    full_load("t1", 2, 9'h000, 0);
    // Bad checksum (byte 00), then recovery with a clean image.
    full_load("t2bad", 2, 9'h100, 0);
    full_load("t2good", 2, 9'h000, 0);
    // Over-range lengths.
    full_load("t3", 16'h0801, 9'h000, 0);
    full_load("t3max1", MAX_WORDS + 1, 9'h000, 0);
    // Zero-length image.
    img.delete();
    full_load("t4ok", 0, 9'h100, 0);
    full_load("t4bad", 0, 9'h101, 0);
    // 16 random words with random input gaps.
    fill(16);
    full_load("t5gap", 16, 9'h000, 7);
    full_load("t5nogap", 16, 9'h000, 0);
    // Random small images, some with corrupted checksums.
    for (int r = 0; r < 6; r++) begin
      int n;
      logic [8:0] ovr;
      n = int'($urandom_range(8, 1));
      fill(n);
      ovr = ($urandom_range(1, 0) == 1) ? {1'b1, 8'($urandom)} : 9'h000;
      full_load($sformatf("rnd%0d", r), n, ovr, 3);
    end
    // Largest legal image.
    fill(MAX_WORDS);
    full_load("tmax", MAX_WORDS, 9'h000, 0);

    // Reset after 2.5 words.
    fill(16);
    start_load(16'd16, 0);
    send_data(0, 10, 0);
    chk("t6_pre_nwrites", wa_q.size(), 2);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("t6_we",    {31'd0, bus.imem_we}, 32'd0);
    chk("t6_waddr", bus.imem_waddr, 32'd0);
    chk("t6_wdata", bus.imem_wdata, 32'd0);
    chk("t6_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("t6_done",  {31'd0, load_done}, 32'd0);
    chk("t6_error", {31'd0, load_error}, 32'd0);
    chk("t6_ww",    {16'd0, words_written}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // start during a load is ignored.
    fill(4);
    start_load(16'd4, 0);
    send_data(0, 5, 0);
    pulse_start();
    chk("t6s_ww",    {16'd0, words_written}, 32'd1);
    chk("t6s_ready", {31'd0, bus.in_ready}, 32'd1);
    send_data(5, 16, 0);
    send_byte(csum_acc, 0);
    repeat (2) @(negedge clk);
    check_result("t6s", 4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
